// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default constants for the APB master sequencer
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_t;

    typedef logic [7:0] data_t;
    typedef logic [7:0] addr_t;

    localparam logic [1:0] IDLE_SEL_DEF       = 2'b00;
    localparam data_t      ERR_DATA_DEF       = 8'hFF;
    localparam int         TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/apb_resp_mux.sv
// rtl/apb_resp_mux.sv - picks ready/rdata of the slave addressed by sel; slave 1 wins on id clash
module apb_resp_mux
    import apb_pkg::*;
(
    input  logic [1:0] sel,
    input  logic [1:0] id1,
    input  logic [1:0] id2,
    input  logic       s1_ready,
    input  logic       s2_ready,
    input  data_t      s1_rdata,
    input  data_t      s2_rdata,
    output logic       sel_ready,
    output data_t      sel_rdata,
    output logic       decode_hit
);

    logic hit1;
    logic hit2;

    always_comb begin
        hit1       = (sel == id1);
        hit2       = (sel == id2);
        decode_hit = hit1 | hit2;
        if (hit1) begin
            sel_ready = s1_ready;
            sel_rdata = s1_rdata;
        end else begin
            sel_ready = s2_ready;
            sel_rdata = s2_rdata;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB SETUP/ACCESS sequencer for two slaves
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter logic [1:0] IDLE_SEL       = IDLE_SEL_DEF,
    parameter data_t      ERR_DATA       = ERR_DATA_DEF,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       write,
    input  logic [1:0] sel,
    input  addr_t      addr,
    input  data_t      wdata,
    input  logic [7:0] wait_cycles,
    input  logic [1:0] id1,
    input  logic [1:0] id2,
    output data_t      rdata,
    output logic       stable,
    output logic       error,
    output logic       apb_write,
    output logic [1:0] apb_sel,
    output logic       apb_enable,
    output addr_t      apb_addr,
    output data_t      apb_wdata,
    output logic [7:0] apb_wait_cycles,
    input  logic       s1_ready,
    input  logic       s2_ready,
    input  data_t      s1_rdata,
    input  data_t      s2_rdata
);

    apb_state_t state_q;
    data_t      rdata_q;
    logic       stable_q;
    logic       error_q;
    logic       apb_write_q;
    logic [1:0] apb_sel_q;
    logic       apb_enable_q;
    addr_t      apb_addr_q;
    data_t      apb_wdata_q;
    logic [7:0] apb_wait_q;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
`endif

    logic [1:0] mux_sel;
    logic       sel_ready;
    data_t      sel_rdata;
    logic       decode_hit;

    assign mux_sel = (state_q == IDLE) ? sel : apb_sel_q;

    apb_resp_mux u_resp_mux (
        .sel        (mux_sel),
        .id1        (id1),
        .id2        (id2),
        .s1_ready   (s1_ready),
        .s2_ready   (s2_ready),
        .s1_rdata   (s1_rdata),
        .s2_rdata   (s2_rdata),
        .sel_ready  (sel_ready),
        .sel_rdata  (sel_rdata),
        .decode_hit (decode_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rdata_q      <= '0;
            stable_q     <= 1'b0;
            error_q      <= 1'b0;
            apb_write_q  <= 1'b0;
            apb_sel_q    <= IDLE_SEL;
            apb_enable_q <= 1'b0;
            apb_addr_q   <= '0;
            apb_wdata_q  <= '0;
            apb_wait_q   <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        apb_write_q <= write;
                        apb_addr_q  <= addr;
                        apb_wdata_q <= wdata;
                        apb_wait_q  <= wait_cycles;
                        if (decode_hit) begin
                            apb_sel_q <= sel;
                            state_q   <= SETUP;
`ifdef APB_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end else begin
                            error_q <= 1'b1;
                            rdata_q <= ERR_DATA;
                            state_q <= DONE;
                        end
                    end
                end
                SETUP: begin
                    apb_enable_q <= 1'b1;
                    state_q      <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        if (!apb_write_q) begin
                            rdata_q <= sel_rdata;
                        end
                        error_q      <= 1'b0;
                        stable_q     <= 1'b1;
                        apb_enable_q <= 1'b0;
                        apb_sel_q    <= IDLE_SEL;
                        state_q      <= DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        rdata_q      <= ERR_DATA;
                        error_q      <= 1'b1;
                        stable_q     <= 1'b1;
                        apb_enable_q <= 1'b0;
                        apb_sel_q    <= IDLE_SEL;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                DONE: begin
                    if (stable_q) begin
                        stable_q <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        stable_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata           = rdata_q;
    assign stable          = stable_q;
    assign error           = error_q;
    assign apb_write       = apb_write_q;
    assign apb_sel         = apb_sel_q;
    assign apb_enable      = apb_enable_q;
    assign apb_addr        = apb_addr_q;
    assign apb_wdata       = apb_wdata_q;
    assign apb_wait_cycles = apb_wait_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed self-checking bench for apb_master_ctrl
module tb_apb_master_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       write;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] wait_cycles;
    logic [1:0] id1;
    logic [1:0] id2;
    logic [7:0] rdata;
    logic       stable;
    logic       error;
    logic       apb_write;
    logic [1:0] apb_sel;
    logic       apb_enable;
    logic [7:0] apb_addr;
    logic [7:0] apb_wdata;
    logic [7:0] apb_wait_cycles;
    logic       s1_ready;
    logic       s2_ready;
    logic [7:0] s1_rdata;
    logic [7:0] s2_rdata;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    apb_master_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .write           (write),
        .sel             (sel),
        .addr            (addr),
        .wdata           (wdata),
        .wait_cycles     (wait_cycles),
        .id1             (id1),
        .id2             (id2),
        .rdata           (rdata),
        .stable          (stable),
        .error           (error),
        .apb_write       (apb_write),
        .apb_sel         (apb_sel),
        .apb_enable      (apb_enable),
        .apb_addr        (apb_addr),
        .apb_wdata       (apb_wdata),
        .apb_wait_cycles (apb_wait_cycles),
        .s1_ready        (s1_ready),
        .s2_ready        (s2_ready),
        .s1_rdata        (s1_rdata),
        .s2_rdata        (s2_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
        write = w;
        sel   = s;
        addr  = a;
        wdata = d;
        start = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; write = 1'b0; sel = 2'd0; addr = 8'h00;
        wdata = 8'h00; wait_cycles = 8'h00; id1 = 2'd1; id2 = 2'd2;
        s1_ready = 1'b0; s2_ready = 1'b0; s1_rdata = 8'h00; s2_rdata = 8'h00;
        cyc(); cyc();
        check("rst_rdata", rdata, 8'h00);
        check("rst_stable", {7'd0, stable}, 8'h00);
        check("rst_error", {7'd0, error}, 8'h00);
        check("rst_sel", {6'd0, apb_sel}, 8'h00);
        check("rst_enable", {7'd0, apb_enable}, 8'h00);
        check("rst_write", {7'd0, apb_write}, 8'h00);
        check("rst_addr", apb_addr, 8'h00);
        check("rst_wdata", apb_wdata, 8'h00);
        check("rst_wait", apb_wait_cycles, 8'h00);
        reset = 1'b0;
        cyc();

        s1_ready = 1'b1; wait_cycles = 8'h03;
        issue(1'b1, 2'd1, 8'h10, 8'hA5);
        cyc(); start = 1'b0;
        check("w_setup_sel", {6'd0, apb_sel}, 8'h01);
        check("w_setup_en", {7'd0, apb_enable}, 8'h00);
        check("w_setup_addr", apb_addr, 8'h10);
        check("w_setup_wdata", apb_wdata, 8'hA5);
        check("w_setup_write", {7'd0, apb_write}, 8'h01);
        check("w_setup_wait", apb_wait_cycles, 8'h03);
        check("w_setup_stable", {7'd0, stable}, 8'h00);
        cyc();
        check("w_acc_en", {7'd0, apb_enable}, 8'h01);
        check("w_acc_sel", {6'd0, apb_sel}, 8'h01);
        check("w_acc_stable", {7'd0, stable}, 8'h00);
        cyc();
        check("w_done_stable", {7'd0, stable}, 8'h01);
        check("w_done_error", {7'd0, error}, 8'h00);
        check("w_done_en", {7'd0, apb_enable}, 8'h00);
        check("w_done_sel", {6'd0, apb_sel}, 8'h00);
        check("w_done_rdata", rdata, 8'h00);
        cyc();
        check("w_after_stable", {7'd0, stable}, 8'h00);

        s1_ready = 1'b1; s1_rdata = 8'hFF; s2_ready = 1'b0; s2_rdata = 8'h3C;
        issue(1'b0, 2'd2, 8'h44, 8'h00);
        cyc(); start = 1'b0;
        check("r_setup_sel", {6'd0, apb_sel}, 8'h02);
        check("r_setup_write", {7'd0, apb_write}, 8'h00);
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("r_wait_stable", {7'd0, stable}, 8'h00);
            check("r_wait_en", {7'd0, apb_enable}, 8'h01);
            cyc();
        end
        s2_ready = 1'b1;
        check("r_acc4_stable", {7'd0, stable}, 8'h00);
        cyc();
        check("r_done_stable", {7'd0, stable}, 8'h01);
        check("r_done_rdata", rdata, 8'h3C);
        check("r_done_error", {7'd0, error}, 8'h00);
        cyc();
        s2_ready = 1'b0;

        issue(1'b0, 2'd3, 8'h99, 8'h00);
        cyc(); start = 1'b0;
        check("dec_t1_stable", {7'd0, stable}, 8'h00);
        check("dec_t1_en", {7'd0, apb_enable}, 8'h00);
        check("dec_t1_sel", {6'd0, apb_sel}, 8'h00);
        cyc();
        check("dec_stable", {7'd0, stable}, 8'h01);
        check("dec_error", {7'd0, error}, 8'h01);
        check("dec_rdata", rdata, 8'hFF);
        check("dec_en", {7'd0, apb_enable}, 8'h00);
        check("dec_sel", {6'd0, apb_sel}, 8'h00);
        cyc();
        check("dec_after_stable", {7'd0, stable}, 8'h00);

        s1_ready = 1'b0;
        issue(1'b1, 2'd1, 8'h20, 8'h11);
        cyc(); start = 1'b0;
        cyc();
        issue(1'b0, 2'd2, 8'h77, 8'h00);
        cyc(); start = 1'b0;
        check("ign_addr", apb_addr, 8'h20);
        check("ign_sel", {6'd0, apb_sel}, 8'h01);
        check("ign_write", {7'd0, apb_write}, 8'h01);
        s1_ready = 1'b1;
        cyc();
        check("ign_stable", {7'd0, stable}, 8'h01);
        check("ign_error", {7'd0, error}, 8'h00);
        check("ign_rdata", rdata, 8'hFF);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (stable) pulses++;
        end
        check("ign_no_extra", 8'(pulses), 8'h00);

        s2_ready = 1'b0;
        issue(1'b0, 2'd2, 8'h30, 8'h00);
        cyc(); start = 1'b0;
        cyc();
        check("rsta_en", {7'd0, apb_enable}, 8'h01);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rsta_en_off", {7'd0, apb_enable}, 8'h00);
        check("rsta_sel", {6'd0, apb_sel}, 8'h00);
        check("rsta_stable", {7'd0, stable}, 8'h00);
        cyc();
        check("rsta_stable2", {7'd0, stable}, 8'h00);
        s1_ready = 1'b1; s1_rdata = 8'h5A;
        issue(1'b0, 2'd1, 8'h31, 8'h00);
        cyc(); start = 1'b0;
        cyc();
        cyc();
        check("fresh_stable", {7'd0, stable}, 8'h01);
        check("fresh_rdata", rdata, 8'h5A);
        cyc();

        s2_ready = 1'b0;
        issue(1'b0, 2'd2, 8'h40, 8'h00);
        cyc(); start = 1'b0;
        cyc();
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            check("to_wait_stable", {7'd0, stable}, 8'h00);
            cyc();
        end
        check("to_acc4_stable", {7'd0, stable}, 8'h00);
        cyc();
        check("to_stable", {7'd0, stable}, 8'h01);
        check("to_error", {7'd0, error}, 8'h01);
        check("to_rdata", rdata, 8'hFF);
        check("to_en", {7'd0, apb_enable}, 8'h00);
        cyc();
`else
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (stable) pulses++;
            cyc();
        end
        check("nto_no_stable", 8'(pulses), 8'h00);
        check("nto_en", {7'd0, apb_enable}, 8'h01);
        check("nto_rdata", rdata, 8'h5A);
`endif
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB master sequencer between the processor-side request bus and the two APB slave ports.
- Accepts one processor transaction at a time and drives the APB SETUP→ACCESS phases to the slave whose id matches the request's sel.
- Returns that slave's ready/rdata to the processor and pulses stable on completion.
- Single outstanding transfer; no pipelining.

Parameters:
- IDLE_SEL, 2'b00, value driven on apb_sel when no transfer is active; no slave may be assigned this id.
- ERR_DATA, 8'hFF, rdata returned on decode error or timeout.
- TIMEOUT_CYCLES, 64, ACCESS cycles without ready before abort (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  processor request strobe; sampled only in IDLE.
- write  in  1  1 = write, 0 = read.
- sel  in  2  target slave id.
- addr  in  8  transfer address.
- wdata  in  8  write data.
- wait_cycles  in  8  wait-cycle hint forwarded to slaves.
- id1, id2  in  2 each  ids of slave 1 and slave 2.
- rdata  out  8  read result to processor.
- stable  out  1  one-cycle completion pulse.
- error  out  1  valid with stable; decode error or timeout.
- apb_write  out  1  APB direction.
- apb_sel  out  2  APB select.
- apb_enable  out  1  APB enable.
- apb_addr  out  8  APB address.
- apb_wdata  out  8  APB write data.
- apb_wait_cycles  out  8  APB wait-cycle hint.
- s1_ready, s2_ready  in  1 each  slave ready signals.
- s1_rdata, s2_rdata  in  8 each  slave read data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rdata=0, stable=0, error=0; apb_sel=IDLE_SEL, apb_enable=0, apb_write=0, apb_addr=0, apb_wdata=0, apb_wait_cycles=0; timeout counter=0. Reset in any state aborts the transfer with no stable pulse.
- States: IDLE, SETUP, ACCESS, DONE (2-bit enum).
- IDLE:
  - If start=1, register write/sel/addr/wdata/wait_cycles into the apb_* output regs.
  - If sel==id1 or sel==id2 → SETUP.
  - Otherwise decode error → DONE with error=1, rdata=ERR_DATA; no APB activity; apb_sel stays IDLE_SEL.
- SETUP (exactly 1 cycle): apb_sel=latched sel, apb_enable=0 → ACCESS.
- ACCESS:
  - apb_enable=1; apb_* outputs held stable.
  - Selected ready: s1_ready if latched sel==id1, else s2_ready. If id1==id2, slave 1 wins.
  - On selected ready=1: read → rdata=selected rdata; write → rdata unchanged. Then → DONE, error=0.
- DONE:
  - stable=1 for exactly one cycle.
  - apb_enable=0, apb_sel=IDLE_SEL.
  - → IDLE.
- start outside IDLE is ignored, not queued. The processor must hold start until stable or re-issue it.
- Latency: zero-wait slave gives start@T → SETUP T+1 → ACCESS T+2 (ready sampled) → stable T+3. Each ACCESS cycle with ready=0 adds 1.
- Decode error: stable at T+2.
- rdata holds its value between transfers.
- Non-selected slave ready/rdata are ignored at all times.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - 8-bit counter clears on SETUP entry and increments each ACCESS cycle with ready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 and ready is still 0 → DONE with error=1, rdata=ERR_DATA.
  - ready in the same cycle as expiry wins: normal completion.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; error asserts only on decode error.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_state_t {IDLE, SETUP, ACCESS, DONE}
  - IDLE_SEL and ERR_DATA default constants
  - 8-bit data/addr typedefs
- Natural sub-module: apb_resp_mux. Combinational selection of ready/rdata from s1/s2 by latched sel vs id1/id2, producing sel_ready, sel_rdata, and a decode_hit flag.

Test Plan:
- id1=1, id2=2; write sel=1, addr=8'h10, wdata=8'hA5, s1_ready tied 1 → SETUP then ACCESS with apb_addr=8'h10, apb_wdata=8'hA5, apb_write=1; stable at T+3, error=0.
- Read sel=2, s2_rdata=8'h3C, s2_ready low 3 ACCESS cycles → stable at T+6, rdata=8'h3C; s1_rdata=8'hFF never appears.
- start with sel=3 (no match) → no apb_enable; stable at T+2, error=1, rdata=8'hFF.
- start pulses again during ACCESS → ignored; exactly one stable; apb_addr unchanged.
- reset asserted during ACCESS → next cycle apb_enable=0, apb_sel=2'b00, no stable; fresh transfer then completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted → stable after 4 ACCESS cycles, error=1, rdata=8'hFF; without the macro, stable never asserts.
